apb_slave_regfile: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 41 ++++
 rtl/apb_slv_regbank.sv | 37 +++
 rtl/apb_slave_regfile.sv | 181 ++++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Purpose: shared types, constants and address decode for the APB register-file completer.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package apb_slv_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int REG_ID_IDX = 0;
  localparam int SPAN_W     = APB_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_e;

  // err flags any access the bank must refuse; idx is the full word index of the offset
  typedef struct packed {
    logic                  err;
    logic [APB_ADDR_W-3:0] idx;
  } apb_slv_dec_t;

  // offset is already (addr - base) modulo the bus width, so addresses below the base
  // wrap to huge offsets and land out of range
  function automatic apb_slv_dec_t apb_slv_decode(
    input logic [APB_ADDR_W-1:0] offset,
    input logic [1:0]            byte_lsb,
    input int unsigned           num_regs,
    input logic                  write
  );
    apb_slv_dec_t      d;
    logic [SPAN_W-1:0] span;
    span  = SPAN_W'(num_regs) << 2;
    d.idx = offset[APB_ADDR_W-1:2];
    d.err = (byte_lsb != 2'b00) ||
            ({1'b0, offset} >= span) ||
            (write && (d.idx == (APB_ADDR_W-2)'(REG_ID_IDX)));
    return d;
  endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// Purpose: word register array with a constant ID register at index 0.
// Latency: write lands on the commit edge; read mux is combinational.
// Backpressure: none, the owning FSM decides when to write.
module apb_slv_regbank
  import apb_slv_pkg::*;
#(
  parameter int                DATA_W   = APB_DATA_W,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = '0
) (
  input  logic                        pclk,
  input  logic                        preset,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [DATA_W-1:0]           wr_dat,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [DATA_W-1:0]           rd_dat
);

  localparam int IW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Clear on reset; the ID slot is never written so its storage stays zero
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_idx != IW'(REG_ID_IDX))) begin
      regs[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = (rd_idx == IW'(REG_ID_IDX)) ? ID_VALUE : regs[rd_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// Purpose: APB4 completer over a NUM_REGS word register bank; optional wait states via APB_SLV_WAIT_STATES_EN.
// Latency: pready in the first access cycle, or after WAIT_CYCLES low access cycles when waits are compiled in.
// Backpressure: pready low during wait states; psel dropped mid-transfer aborts without commit.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int                ADDR_W      = APB_ADDR_W,
  parameter int                DATA_W      = APB_DATA_W,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IW = $clog2(NUM_REGS);

  apb_slv_state_e state, state_n;

  // Setup-phase capture: decoded index and error stand in for the raw address
  logic              lat_write;
  logic              lat_err;
  logic [IW-1:0]     lat_idx;
  logic [DATA_W-1:0] lat_wdata;

  logic              pready_q, pready_n;
  logic              pslverr_q, pslverr_n;
  logic [DATA_W-1:0] prdata_q, prdata_n;

  logic              cap;
  logic              commit;
  logic [IW-1:0]     rd_idx;
  logic [DATA_W-1:0] rd_dat;

`ifdef APB_SLV_WAIT_STATES_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt, cnt_n;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  // Decode straight off the bus; only consumed while IDLE sees a setup phase
  logic [ADDR_W-1:0]     offset;
  logic [APB_ADDR_W-1:0] offset_ext;
  apb_slv_dec_t          dec;
  logic [IW-1:0]         dec_idx;
  logic                  unused_idx_hi;

  assign offset        = paddr - BASE_ADDR;
  assign offset_ext    = APB_ADDR_W'(offset);
  assign dec           = apb_slv_decode(offset_ext, paddr[1:0], NUM_REGS, pwrite);
  assign dec_idx       = dec.idx[IW-1:0];
  assign unused_idx_hi = ^dec.idx[APB_ADDR_W-3:IW];

  apb_slv_regbank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .pclk   (pclk),
    .preset (preset),
    .wr_en  (commit),
    .wr_idx (lat_idx),
    .wr_dat (lat_wdata),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat)
  );

  // Next state, next registered response, capture and commit strobes
  always_comb begin
    state_n   = state;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    cap       = 1'b0;
    commit    = 1'b0;
    rd_idx    = lat_idx;
`ifdef APB_SLV_WAIT_STATES_EN
    cnt_n     = cnt;
`endif
    case (state)
      IDLE: begin
        rd_idx = dec_idx;
        if (psel && !penable) begin
          cap       = 1'b1;
          state_n   = RESP;
          pready_n  = 1'b1;
          pslverr_n = dec.err;
          prdata_n  = (pwrite || dec.err) ? '0 : rd_dat;
`ifdef APB_SLV_WAIT_STATES_EN
          if (WAIT_CYCLES > 0) begin
            state_n   = WAIT;
            pready_n  = 1'b0;
            pslverr_n = 1'b0;
            prdata_n  = '0;
            cnt_n     = CW'(WAIT_CYCLES);
          end
`endif
        end
      end
`ifdef APB_SLV_WAIT_STATES_EN
      WAIT: begin
        if (!psel) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (penable) begin
          if (cnt == CW'(1)) begin
            state_n   = RESP;
            pready_n  = 1'b1;
            pslverr_n = lat_err;
            prdata_n  = (lat_write || lat_err) ? '0 : rd_dat;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
`endif
      RESP: begin
        if (psel && penable) begin
          commit  = lat_write && !lat_err;
          state_n = IDLE;
        end else if (!psel) begin
          state_n = IDLE;
        end else begin
          // requester stalled the access phase: keep presenting the response
          pready_n  = pready_q;
          pslverr_n = pslverr_q;
          prdata_n  = prdata_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, capture and response registers; reset aborts any transfer in flight
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
`ifdef APB_SLV_WAIT_STATES_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      pready_q  <= pready_n;
      pslverr_q <= pslverr_n;
      prdata_q  <= prdata_n;
`ifdef APB_SLV_WAIT_STATES_EN
      cnt       <= cnt_n;
`endif
      if (cap) begin
        lat_write <= pwrite;
        lat_err   <= dec.err;
        lat_idx   <= dec_idx;
        lat_wdata <= pwdata;
      end
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Purpose: randomized and directed bench for apb_slave_regfile against an address-map model.
// Latency: expects 0 wait cycles, or 2 when APB_SLV_WAIT_STATES_EN is defined.
// Backpressure: exercises psel abort and mid-transfer reset.
module tb_apb_slave_regfile;

  localparam int          NR = 16;
  localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_SLV_WAIT_STATES_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] model [NR];

  apb_slave_regfile #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_REGS    (NR),
    .BASE_ADDR   (32'h0000_0000),
    .ID_VALUE    (ID),
    .WAIT_CYCLES (2)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  always #5 pclk = ~pclk;

  // One APB transfer; leaves psel/penable high so a following call is back-to-back
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge pclk);
    paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    pwdata  = $urandom();
    waits   = 0;
    while (pready !== 1'b1 && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    rd  = prdata;
    err = pslverr;
    if (pready !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL timeout addr=%h pready=%b required 1", addr, pready);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge pclk);
    n_vec++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got rdy=%b err=%b rd=%h required 0/0/0", pready, pslverr, prdata);
    end
    preset = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic test_rw_basic();
    logic [31:0] rd; logic err; int w;
    xfer(32'h04, 1'b1, 32'hDEADBEEF, rd, err, w);
    n_vec++;
    if (err !== 1'b0 || w != EXP_WAITS) begin
      n_bad++; $display("FAIL wr04 got err=%b waits=%0d required 0/%0d", err, w, EXP_WAITS);
    end
    model[1] = 32'hDEADBEEF;
    xfer(32'h04, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || w != EXP_WAITS) begin
      n_bad++; $display("FAIL rd04 got rd=%h err=%b waits=%0d required deadbeef/0/%0d", rd, err, w, EXP_WAITS);
    end
    idle();
  endtask

  task automatic test_id_reg();
    logic [31:0] rd; logic err; int w;
    xfer(32'h00, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== ID || err !== 1'b0) begin
      n_bad++; $display("FAIL id_read got rd=%h err=%b required %h/0", rd, err, ID);
    end
    xfer(32'h00, 1'b1, 32'h1234, rd, err, w);
    n_vec++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_bad++; $display("FAIL id_write got err=%b rd=%h required 1/0", err, rd);
    end
    xfer(32'h00, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== ID || err !== 1'b0) begin
      n_bad++; $display("FAIL id_reread got rd=%h err=%b required %h/0", rd, err, ID);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int w;
    xfer(32'h06, 1'b1, 32'h5555_AAAA, rd, err, w);
    n_vec++;
    if (err !== 1'b1) begin
      n_bad++; $display("FAIL unaligned_wr got err=%b required 1", err);
    end
    xfer(32'h40, 1'b1, 32'h7777_8888, rd, err, w);
    n_vec++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_bad++; $display("FAIL oor_wr got err=%b rd=%h required 1/0", err, rd);
    end
    xfer(32'h04, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== model[1] || err !== 1'b0) begin
      n_bad++; $display("FAIL rd04_after_err got rd=%h err=%b required %h/0", rd, err, model[1]);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int w;
    xfer(32'h08, 1'b1, 32'h1, rd, err, w);
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_wr08 got err=%b required 0", err); end
    xfer(32'h0C, 1'b1, 32'h2, rd, err, w);
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_wr0c got err=%b required 0", err); end
    model[2] = 32'h1; model[3] = 32'h2;
    xfer(32'h08, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== 32'h1 || err !== 1'b0 || w != EXP_WAITS) begin
      n_bad++; $display("FAIL b2b_rd08 got rd=%h err=%b waits=%0d required 1/0/%0d", rd, err, w, EXP_WAITS);
    end
    xfer(32'h0C, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== 32'h2 || err !== 1'b0 || w != EXP_WAITS) begin
      n_bad++; $display("FAIL b2b_rd0c got rd=%h err=%b waits=%0d required 2/0/%0d", rd, err, w, EXP_WAITS);
    end
    idle();
  endtask

  // Drop psel in the first access cycle of a write: nothing may be committed
  task automatic test_abort();
    logic [31:0] rd; logic err; int w; int hi;
    @(negedge pclk);
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h5A5A_5A5A; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    n_vec++;
    if (pready !== (EXP_WAITS == 0)) begin
      n_bad++; $display("FAIL abort_first_access got rdy=%b required %b", pready, EXP_WAITS == 0);
    end
    psel = 1'b0; penable = 1'b0;
    hi = 0;
    repeat (4) begin
      @(negedge pclk);
      if (pready !== 1'b0) hi++;
    end
    n_vec++;
    if (hi != 0) begin n_bad++; $display("FAIL abort_pready got %0d high cycles required 0", hi); end
    xfer(32'h10, 1'b0, 32'h0, rd, err, w);
    n_vec++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_commit got rd=%h err=%b required 0/0", rd, err);
    end
    xfer(32'h10, 1'b1, 32'h77, rd, err, w);
    xfer(32'h10, 1'b0, 32'h0, rd, err, w);
    model[4] = 32'h77;
    n_vec++;
    if (rd !== 32'h77 || err !== 1'b0 || w != EXP_WAITS) begin
      n_bad++; $display("FAIL abort_recover got rd=%h err=%b waits=%0d required 77/0/%0d", rd, err, w, EXP_WAITS);
    end
    idle();
  endtask

  // One-cycle reset during the first access cycle of a write to 0x14
  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int w;
    @(negedge pclk);
    paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hABCD_0123; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1; preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    n_vec++;
    if ({pready, pslverr, prdata} !== 34'd0) begin
      n_bad++; $display("FAIL reset_mid_outputs got rdy=%b err=%b rd=%h required 0/0/0", pready, pslverr, prdata);
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int i = 0; i < NR; i++) begin
      xfer(32'(i * 4), 1'b0, 32'h0, rd, err, w);
      n_vec++;
      if (rd !== ((i == 0) ? ID : 32'h0) || err !== 1'b0) begin
        n_bad++; $display("FAIL reset_mid_reg%0d got rd=%h err=%b required %h/0", i, rd, err, (i == 0) ? ID : 32'h0);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, exp_rd; logic wr, err, exp_err; int w, sel, widx;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       addr = 32'($urandom_range(0, NR - 1) * 4);
      else if (sel == 6) addr = 32'($urandom_range(0, NR * 4 - 1)) | 32'h1;
      else if (sel == 7) addr = 32'($urandom_range(NR, 63) * 4);
      else if (sel == 8) addr = $urandom();
      else               addr = 32'h0;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      widx    = int'(addr / 4);
      exp_err = (addr % 4 != 0) || (addr >= 4 * NR) || (wr && widx == 0);
      if (exp_err || wr) exp_rd = 32'h0;
      else if (widx == 0) exp_rd = ID;
      else exp_rd = model[widx];
      xfer(addr, wr, wd, rd, err, w);
      n_vec++;
      if (rd !== exp_rd || err !== exp_err || w != EXP_WAITS) begin
        n_bad++;
        $display("FAIL rand%0d addr=%h wr=%b got rd=%h err=%b waits=%0d required %h/%b/%0d",
                 n, addr, wr, rd, err, w, exp_rd, exp_err, EXP_WAITS);
      end
      if (wr && !exp_err) model[widx] = wd;
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rw_basic();
    test_id_reg();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
